// File: rtl/button_conditioner.sv
// Turns nine raw active-low push-buttons into clean one-cycle press pulses:
// 2-flop synchroniser, per-bit debounce, rise detection, lowest-index-first queue.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [8:0] buttons_raw_n,
  output logic [8:0] buttons,
  output logic [8:0] buttons_held,
  output logic       any_held
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [8:0]       sync1;
  logic [8:0]       sync2;
  logic [8:0]       held;
  logic [8:0]       held_d;
  logic [8:0]       pending;
  logic [8:0]       rise;
  logic [8:0]       req;
  logic [8:0]       grant;
  logic [CNT_W-1:0] cnt [9];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~buttons_raw_n;
      sync2 <= sync1;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never flip held.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (sync2[i] == held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          held[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Disabling empties the request vector, which both drops new rises and flushes pending.
  always_comb begin
    rise  = held & ~held_d;
    req   = enable ? (pending | rise) : 9'd0;
    grant = req & (~req + 9'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_d       <= '0;
      pending      <= '0;
      buttons      <= '0;
      buttons_held <= '0;
      any_held     <= 1'b0;
    end else begin
      held_d       <= held;
      pending      <= req & ~grant;
      buttons      <= grant;
      buttons_held <= held;
      any_held     <= |held;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; pulse timing is
// counted in edges from the first edge at which the synchroniser sees the new level.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [8:0] raw_n;
  logic [8:0] buttons;
  logic [8:0] buttons_held;
  logic       any_held;

  int checks = 0;
  int failures = 0;
  int onehot_viol = 0;

  int         edge_n;
  int         npulse;
  int         first_edge;
  int         last_edge;
  int         held_on;
  int         held_off;
  logic [8:0] seq [4];

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .buttons_raw_n(raw_n),
    .buttons      (buttons),
    .buttons_held (buttons_held),
    .any_held     (any_held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(buttons) > 1) onehot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    edge_n     = 0;
    npulse     = 0;
    first_edge = -1;
    last_edge  = -1;
    held_on    = -1;
    held_off   = -1;
    for (int i = 0; i < 4; i++) seq[i] = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (buttons != 9'd0) begin
        if (npulse < 4) seq[npulse] = buttons;
        if (npulse == 0) first_edge = edge_n;
        last_edge = edge_n;
        npulse++;
      end
      if (any_held && held_on < 0) held_on = edge_n;
      if (!any_held && held_off < 0) held_off = edge_n;
      edge_n++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    raw_n  = 9'h1FF;
    clr_stats();
    run(3);
    check("reset_buttons", buttons, 9'h000);
    check("reset_held", buttons_held, 9'h000);
    check("reset_any", any_held, 1'b0);
    rst = 1'b0;
    run(3);

    // 1: clean press of [4]
    clr_stats();
    raw_n[4] = 1'b0;
    run(20);
    check("s1_npulse", npulse, 1);
    check("s1_val", seq[0], 9'h010);
    check("s1_edge", first_edge, 6);
    check("s1_held_on", held_on, 6);
    check("s1_held_lvl", buttons_held, 9'h010);
    check("s1_any", any_held, 1'b1);
    clr_stats();
    raw_n[4] = 1'b1;
    run(10);
    check("s1_rel_npulse", npulse, 0);
    check("s1_held_off", held_off, 6);

    // 2: bouncing [2], then stable low
    clr_stats();
    for (int b = 0; b < 3; b++) begin
      raw_n[2] = 1'b0;
      run(2);
      raw_n[2] = 1'b1;
      run(2);
    end
    check("s2_bounce_npulse", npulse, 0);
    check("s2_bounce_held", held_on, 32'hFFFF_FFFF);
    clr_stats();
    raw_n[2] = 1'b0;
    run(12);
    check("s2_npulse", npulse, 1);
    check("s2_val", seq[0], 9'h004);
    check("s2_edge", first_edge, 6);
    raw_n[2] = 1'b1;
    run(10);

    // 3: simultaneous [0],[4],[8]
    clr_stats();
    raw_n = 9'h1FF & ~9'h111;
    run(14);
    check("s3_npulse", npulse, 3);
    check("s3_first", seq[0], 9'h001);
    check("s3_second", seq[1], 9'h010);
    check("s3_third", seq[2], 9'h100);
    check("s3_first_edge", first_edge, 6);
    check("s3_last_edge", last_edge, 8);
    raw_n = 9'h1FF;
    run(10);

    // 4: glitch on [7], then enable handling on [1]
    clr_stats();
    raw_n[7] = 1'b0;
    run(3);
    raw_n[7] = 1'b1;
    run(10);
    check("s4_glitch_npulse", npulse, 0);
    check("s4_glitch_held", held_on, 32'hFFFF_FFFF);
    clr_stats();
    enable   = 1'b0;
    raw_n[1] = 1'b0;
    run(10);
    check("s4_dis_npulse", npulse, 0);
    check("s4_dis_held", buttons_held, 9'h002);
    enable = 1'b1;
    run(6);
    check("s4_reen_npulse", npulse, 0);
    raw_n[1] = 1'b1;
    run(10);
    clr_stats();
    raw_n[1] = 1'b0;
    run(12);
    check("s4_press_npulse", npulse, 1);
    check("s4_press_val", seq[0], 9'h002);
    check("s4_press_edge", first_edge, 6);
    raw_n[1] = 1'b1;
    run(10);

    // 5: reset while cnt[5] == 2
    clr_stats();
    raw_n[5] = 1'b0;
    run(4);
    rst = 1'b1;
    run(3);
    check("s5_rst_buttons", buttons, 9'h000);
    check("s5_rst_held", buttons_held, 9'h000);
    check("s5_rst_any", any_held, 1'b0);
    check("s5_rst_npulse", npulse, 0);
    rst = 1'b0;
    clr_stats();
    run(12);
    check("s5_npulse", npulse, 1);
    check("s5_val", seq[0], 9'h020);
    check("s5_edge", first_edge, 6);
    raw_n[5] = 1'b1;
    run(10);

    // 6: enable drops while [3] is on the output, [6] must be flushed
    clr_stats();
    raw_n = 9'h1FF & ~9'h048;
    for (int i = 0; i < 20 && npulse == 0; i++) run(1);
    check("s6_found", npulse, 1);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(6);
    check("s6_npulse", npulse, 1);
    check("s6_val", seq[0], 9'h008);
    check("s6_edge", first_edge, 6);
    raw_n = 9'h1FF;
    run(10);

    check("onehot_invariant", onehot_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
